// File: rtl/current_bank_if.sv
// -----------------------------------------------------------------------------
// current_bank_if
// Bundles the current-bank ports seen by the spike router, the neuron update
// engine and the timestep sequencer.
//   acc_valid/acc_ready/acc_tag/acc_weight : signed accumulate into I_next
//   rd_tag/rd_value                        : registered read of I
//   nx_tag/nx_value                        : registered read of I_next (monitor)
//   swap_req/swap_busy/swap_done           : timestep swap sweep handshake
// master = client side, slave = current_bank.
// -----------------------------------------------------------------------------
interface current_bank_if #(
    parameter int TAG_W = 4,
    parameter int WIDTH = 16
);
    logic                    acc_valid;
    logic                    acc_ready;
    logic [TAG_W-1:0]        acc_tag;
    logic signed [WIDTH-1:0] acc_weight;
    logic [TAG_W-1:0]        rd_tag;
    logic signed [WIDTH-1:0] rd_value;
    logic [TAG_W-1:0]        nx_tag;
    logic signed [WIDTH-1:0] nx_value;
    logic                    swap_req;
    logic                    swap_busy;
    logic                    swap_done;

    modport master (
        output acc_valid, acc_tag, acc_weight, rd_tag, nx_tag, swap_req,
        input  acc_ready, rd_value, nx_value, swap_busy, swap_done
    );

    modport slave (
        input  acc_valid, acc_tag, acc_weight, rd_tag, nx_tag, swap_req,
        output acc_ready, rd_value, nx_value, swap_busy, swap_done
    );
endinterface

// File: rtl/current_bank.sv
// -----------------------------------------------------------------------------
// current_bank
// Per-neuron synaptic current store: I (current timestep) and I_next
// (accumulator for the next timestep). Spikes accumulate signed weights into
// I_next; the neuron engine reads I through a 1-cycle registered port. A swap
// sweep copies I_next[k] into I[k] and leaks I_next[k] by >>> DECAY_SHIFT,
// one neuron per cycle.
//
// Ports:
//   clk        : clock, rising edge
//   asyn_reset : synchronous active-high reset (clears both arrays)
//   bus        : current_bank_if.slave (accumulate, read, swap handshake)
//
// Build option: define CURRENT_SAT_EN to saturate the accumulate add;
// otherwise it wraps modulo 2^WIDTH.
// -----------------------------------------------------------------------------
module current_bank #(
    parameter int NUM_NEURONS = 16,
    parameter int WIDTH       = 16,
    parameter int TAG_W       = 4,
    parameter int DECAY_SHIFT = 2
) (
    input  logic          clk,
    input  logic          asyn_reset,
    current_bank_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

    localparam logic [TAG_W-1:0] LAST_K = TAG_W'(NUM_NEURONS - 1);

    state_t                  state_q, state_d;
    logic [TAG_W-1:0]        k_q, k_d;
    logic signed [WIDTH-1:0] cur_q [NUM_NEURONS];
    logic signed [WIDTH-1:0] nxt_q [NUM_NEURONS];
    logic signed [WIDTH-1:0] rd_value_q, nx_value_q;
    logic signed [WIDTH-1:0] acc_old, acc_sum, rd_sel, nx_sel;
    logic                    acc_fire;

    function automatic logic signed [WIDTH-1:0] acc_add(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
`ifdef CURRENT_SAT_EN
        logic signed [WIDTH:0] s;
        s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        // Sign bits disagree only when the true sum left the WIDTH-bit range.
        if (s[WIDTH] != s[WIDTH-1])
            return s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return s[WIDTH-1:0];
`else
        return a + b;
`endif
    endfunction

    // Arithmetic shift rounds toward -inf, so small negatives leak to 0
    // and the result always stays within range.
    function automatic logic signed [WIDTH-1:0] leak(input logic signed [WIDTH-1:0] v);
        return v - (v >>> DECAY_SHIFT);
    endfunction

    assign acc_fire      = bus.acc_valid & bus.acc_ready;
    assign bus.acc_ready = ~asyn_reset & (state_q != S_SWEEP);
    assign bus.swap_busy = (state_q == S_SWEEP);
    assign bus.swap_done = (state_q == S_DONE);
    assign bus.rd_value  = rd_value_q;
    assign bus.nx_value  = nx_value_q;

    // Tag decode by compare so out-of-range tags simply select nothing.
    always_comb begin
        acc_old = '0;
        rd_sel  = '0;
        nx_sel  = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (bus.acc_tag == TAG_W'(i)) acc_old = nxt_q[i];
            if (bus.rd_tag  == TAG_W'(i)) rd_sel  = cur_q[i];
            if (bus.nx_tag  == TAG_W'(i)) nx_sel  = nxt_q[i];
        end
        acc_sum = acc_add(acc_old, bus.acc_weight);
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (bus.swap_req) begin
                    state_d = S_SWEEP;
                    k_d     = '0;
                end
            end
            S_SWEEP: begin
                k_d = k_q + 1'b1;
                if (k_q == LAST_K) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (asyn_reset) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            rd_value_q <= '0;
            nx_value_q <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                cur_q[i] <= '0;
                nxt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            rd_value_q <= rd_sel;
            nx_value_q <= nx_sel;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (state_q == S_SWEEP && k_q == TAG_W'(i)) begin
                    cur_q[i] <= nxt_q[i];
                    nxt_q[i] <= leak(nxt_q[i]);
                end else if (acc_fire && bus.acc_tag == TAG_W'(i)) begin
                    nxt_q[i] <= acc_sum;
                end
            end
        end
    end

endmodule

// File: doc/current_bank.md
# current_bank

Parametrised per-neuron synaptic current store for the Izhikevich graph accelerator, holding the current-timestep array I and the next-timestep accumulator I_next. Spike routing accumulates signed weights into I_next through a ready/valid port, while the neuron update engine reads I through a registered read port. At a timestep boundary, a sequential swap sweep copies I_next into I and applies a configurable leaky decay to I_next, one neuron per cycle, with a busy/done handshake.

## Interface
Parameters:
- NUM_NEURONS, 16, number of neurons (≥2)
- WIDTH, 16, current width, two's complement signed
- TAG_W, 4, neuron index width; must be ≥ clog2(NUM_NEURONS)
- DECAY_SHIFT, 2, leak shift; legal range 1..WIDTH-1

Ports:
- clk  in  1  clock; all logic on rising edge
- asyn_reset  in  1  synchronous, active-high reset
- acc_valid  in  1  accumulate request
- acc_ready  out  1  accumulate port can accept
- acc_tag  in  TAG_W  target neuron of accumulate
- acc_weight  in  WIDTH  signed weight added to I_next[acc_tag]
- rd_tag  in  TAG_W  I read index
- rd_value  out  WIDTH  registered I[rd_tag]
- nx_tag  in  TAG_W  I_next read index (debug/monitor)
- nx_value  out  WIDTH  registered I_next[nx_tag]
- swap_req  in  1  start timestep swap (one-cycle pulse)
- swap_busy  out  1  sweep in progress
- swap_done  out  1  one-cycle pulse when sweep completes

## Operation
- States: IDLE, SWEEP, DONE. Sweep index k has TAG_W bits.
- IDLE: acc_ready=1. A handshake (acc_valid & acc_ready) sets I_next[acc_tag] <= I_next[acc_tag] + acc_weight. Read-modify-write completes in one cycle, so back-to-back writes to the same tag both take effect. A tag ≥ NUM_NEURONS is accepted and discarded.
- IDLE & swap_req -> SWEEP, with k=0. An accumulate accepted in the same cycle is applied first and is therefore included in the new I.
- SWEEP: acc_ready=0 and swap_busy=1. Each cycle: I[k] <= I_next[k]; I_next[k] <= I_next[k] - (I_next[k] >>> DECAY_SHIFT); k <= k+1. The shift is arithmetic, so -1 decays to 0. After k = NUM_NEURONS-1 -> DONE.
- DONE: swap_done=1 for one cycle, swap_busy=0, acc_ready=1. Accumulates are accepted in this cycle. Next state is IDLE.
- swap_req in SWEEP or DONE is ignored and does not queue.
- Reads are allowed in every state. During SWEEP, rd_value reflects the partially updated I; the consumer waits for swap_done.
- Reset (at any time, including mid-sweep): all I and I_next entries = 0, state IDLE, k = 0.

## Timing
- Reset values: acc_ready=1 once reset deasserts (0 while asserted); rd_value=0, nx_value=0, swap_busy=0, swap_done=0.
- Read latency is 1 cycle: rd_value/nx_value show the array contents before this edge's writes (read-before-write on the same tag).
- Accumulate is visible on nx_value 2 cycles after the handshake when nx_tag matches.
- Swap latency: swap_req at cycle t gives swap_busy high during t+1..t+NUM_NEURONS, and swap_done at t+NUM_NEURONS+1.
- Throughput is 1 accumulate per cycle outside SWEEP.

## Configuration
- CURRENT_SAT_EN defined: the accumulate add saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; decay cannot overflow.
- CURRENT_SAT_EN undefined: the accumulate wraps modulo 2^WIDTH; no clamp logic is built.

## Test plan
- Reset mid-sweep: swap_req, then assert asyn_reset at sweep index 5 -> all reads 0, swap_busy=0, no swap_done, acc_ready=1 after release.
- Accumulate/read: +100 then -30 to tag 3 on consecutive cycles -> nx_value(3)=70; rd_value(3)=0 until swap.
- Swap/decay (DECAY_SHIFT=2): I_next[3]=100, I_next[4]=-100, swap_req -> after swap_done, I[3]=100, I[4]=-100, I_next[3]=75, I_next[4]=-75; swap_done exactly NUM_NEURONS+1 cycles after the request.
- Simultaneous events: acc_valid (tag 0, +5) together with swap_req -> I[0]=5; acc_ready low for NUM_NEURONS cycles; swap_req during the sweep yields exactly one swap_done.
- Overflow: I_next[1]=32000, add 1000 -> 32767 with CURRENT_SAT_EN, -32536 without.
- Out-of-range tag: acc_tag=NUM_NEURONS with weight 7 -> handshake completes; no I_next entry changes.
